// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
//
// Buffers execution-unit writebacks (up to two per cycle) in an in-order FIFO
// and retires them one per cycle through the register file's single write
// port. Write 1 is always ordered ahead of write 2 within a cycle. When the
// queue is empty, the oldest incoming write skips the FIFO and lands in the
// output registers at the same edge.
//
// Optional feature: define WRITEBACK_BYPASS_EN to build the forwarding lookup
// (youngest pending GPR value for lookupAddress_i). When it is undefined,
// lookupHit_o/lookupVal_o are tied to 0 and no compare logic is built.
//
// Ports
//   clock_i, reset_i                 clock; synchronous active-low reset
//   functionalUnitCode_i             unit code shared by both incoming writes
//   reg{1,2}WritebackEnable_i        per-port write valid
//   reg{1,2}WritebackAddress_i       per-port target register
//   reg{1,2}WritebackVal_i           per-port value
//   stall_o                          fewer than two free slots
//   overflow_o                       sticky: a write was dropped
//   regWriteEnable_o                 registered register-file write strobe
//   regWriteSlot2_o                  retiring entry came from port 2
//   regWriteUnitCode_o               unit code of retiring entry
//   regWriteAddress_o/regWriteVal_o  retiring target and value
//   lookupAddress_i                  forwarding query address
//   lookupHit_o/lookupVal_o          forwarding result
// -----------------------------------------------------------------------------
module writeback_queue #(
    parameter int regWidth   = 5,
    parameter int dataWidth  = 64,
    parameter int queueDepth = 4,
    parameter int ptrWidth   = 2
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [2:0]           functionalUnitCode_i,
    input  logic                 reg1WritebackEnable_i,
    input  logic                 reg2WritebackEnable_i,
    input  logic [regWidth-1:0]  reg1WritebackAddress_i,
    input  logic [regWidth-1:0]  reg2WritebackAddress_i,
    input  logic [dataWidth-1:0] reg1WritebackVal_i,
    input  logic [dataWidth-1:0] reg2WritebackVal_i,
    output logic                 stall_o,
    output logic                 overflow_o,
    output logic                 regWriteEnable_o,
    output logic                 regWriteSlot2_o,
    output logic [2:0]           regWriteUnitCode_o,
    output logic [regWidth-1:0]  regWriteAddress_o,
    output logic [dataWidth-1:0] regWriteVal_o,
    input  logic [regWidth-1:0]  lookupAddress_i,
    output logic                 lookupHit_o,
    output logic [dataWidth-1:0] lookupVal_o
);

    typedef struct packed {
        logic                 slot2;
        logic [2:0]           unit_code;
        logic [regWidth-1:0]  addr;
        logic [dataWidth-1:0] val;
    } entry_t;

    localparam logic [ptrWidth:0] DEPTH     = (ptrWidth+1)'(queueDepth);
    localparam logic [ptrWidth:0] STALL_LVL = (ptrWidth+1)'(queueDepth - 2);

    entry_t              mem [queueDepth];
    logic [ptrWidth-1:0] head;
    logic [ptrWidth-1:0] tail;
    logic [ptrWidth:0]   count;
    entry_t              out_q;
    logic                out_vld;
    logic                overflow_q;

    entry_t              in1;
    entry_t              in2;
    entry_t              pass_entry;
    logic                pop;
    logic                pass;
    logic                take1;
    logic                take2;
    logic                acc1;
    logic                acc2;
    logic                drop;
    logic [ptrWidth:0]   free_slots;
    logic [ptrWidth-1:0] tail2;
    logic [ptrWidth:0]   count_nxt;

    assign in1 = '{slot2: 1'b0, unit_code: functionalUnitCode_i,
                   addr: reg1WritebackAddress_i, val: reg1WritebackVal_i};
    assign in2 = '{slot2: 1'b1, unit_code: functionalUnitCode_i,
                   addr: reg2WritebackAddress_i, val: reg2WritebackVal_i};

    // Push/pop decision. Free space is judged on the registered count only:
    // the slot freed by this edge's pop is not reusable in the same cycle,
    // which keeps the accept path independent of the pop path.
    always_comb begin
        pop        = 1'b0;
        pass       = 1'b0;
        pass_entry = in1;
        take1      = 1'b0;
        take2      = 1'b0;
        acc1       = 1'b0;
        acc2       = 1'b0;
        drop       = 1'b0;
        free_slots = DEPTH - count;
        tail2      = tail;
        count_nxt  = count;

        pop  = (count != '0);
        pass = (count == '0) && (reg1WritebackEnable_i || reg2WritebackEnable_i);
        pass_entry = reg1WritebackEnable_i ? in1 : in2;

        // Whichever write went straight to the output is not enqueued.
        take1 = reg1WritebackEnable_i && !pass;
        take2 = reg2WritebackEnable_i && !(pass && !reg1WritebackEnable_i);

        acc1 = take1 && (free_slots != '0);
        acc2 = take2 && (free_slots > (ptrWidth+1)'(acc1));
        drop = (take1 && !acc1) || (take2 && !acc2);

        tail2     = tail + ptrWidth'(acc1);
        count_nxt = count + (ptrWidth+1)'(acc1) + (ptrWidth+1)'(acc2)
                          - (ptrWidth+1)'(pop);
    end

    // Entry storage carries no reset; validity is tracked by head/count.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            if (acc1) mem[tail]  <= in1;
            if (acc2) mem[tail2] <= in2;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
            out_vld    <= 1'b0;
            out_q      <= '0;
        end else begin
            head    <= head + ptrWidth'(pop);
            tail    <= tail + ptrWidth'(acc1) + ptrWidth'(acc2);
            count   <= count_nxt;
            out_vld <= pop || pass;
            // Output fields hold their last value when nothing retires.
            if (pop)
                out_q <= mem[head];
            else if (pass)
                out_q <= pass_entry;
            if (drop)
                overflow_q <= 1'b1;
        end
    end

    assign stall_o            = (count > STALL_LVL);
    assign overflow_o         = overflow_q;
    assign regWriteEnable_o   = out_vld;
    assign regWriteSlot2_o    = out_q.slot2;
    assign regWriteUnitCode_o = out_q.unit_code;
    assign regWriteAddress_o  = out_q.addr;
    assign regWriteVal_o      = out_q.val;

`ifdef WRITEBACK_BYPASS_EN
    // Forwarding search. The output register is the oldest pending write, so
    // it is checked first; FIFO entries are walked head to tail so that a
    // later (younger) match overrides an earlier one. Port-2 entries never
    // forward because they target CR/XER rather than the GPR file.
    logic [ptrWidth-1:0] idx;

    always_comb begin
        lookupHit_o = 1'b0;
        lookupVal_o = '0;
        idx         = head;
        if (out_vld && !out_q.slot2 && (out_q.addr == lookupAddress_i)) begin
            lookupHit_o = 1'b1;
            lookupVal_o = out_q.val;
        end
        for (int i = 0; i < queueDepth; i++) begin
            idx = head + ptrWidth'(i);
            if (((ptrWidth+1)'(i) < count) && !mem[idx].slot2 &&
                (mem[idx].addr == lookupAddress_i)) begin
                lookupHit_o = 1'b1;
                lookupVal_o = mem[idx].val;
            end
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = ^lookupAddress_i;
    assign lookupHit_o   = 1'b0;
    assign lookupVal_o   = '0;
`endif

endmodule
